// File: rtl/req_queue_pkg.sv
// Shared state type and default sizing for the request queue controller.
package req_queue_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 8;
    localparam int unsigned DEF_NREQ  = 2;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant among requesters; priority moves past each winner.
module rr_arbiter
    import req_queue_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_en,
    output logic [NREQ-1:0] o_gnt
);

    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam int unsigned SUM_W = PTR_W + 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_sel;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [SUM_W-1:0] w_sum;
    logic             w_found;

    // Scan requesters starting at the priority pointer, wrapping modulo NREQ.
    always_comb begin
        o_gnt     = '0;
        w_found   = 1'b0;
        w_sel     = '0;
        w_sum     = '0;
        w_ptr_nxt = r_ptr;
        for (int k = 0; k < int'(NREQ); k++) begin
            w_sum = {1'b0, r_ptr} + SUM_W'(k);
            if (w_sum >= SUM_W'(NREQ)) begin
                w_sum = w_sum - SUM_W'(NREQ);
            end
            if (i_en && !w_found && i_req[w_sum[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[PTR_W-1:0];
            end
        end
        if (w_found) begin
            o_gnt[w_sel] = 1'b1;
            w_ptr_nxt    = (w_sel == PTR_W'(NREQ - 1)) ? '0 : w_sel + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/req_queue_ctrl.sv
// Multi-requester in-order queue with round-robin admission and a drain mode.
// Define REQQ_BYPASS_EN to forward a grant straight to the head when the queue is empty.
module req_queue_ctrl
    import req_queue_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned NREQ  = DEF_NREQ
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ-1:0][WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]              req_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    input  logic                         drain,
    output logic                         drain_done,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_drain_done;
    logic             w_drain_fin;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_arb_en;
    logic [NREQ-1:0]  w_gnt;
    logic             w_push;
    logic             w_store;
    logic             w_pop;
    logic             w_head_vld;
    logic             w_bypass;
    logic [WIDTH-1:0] w_push_data;
    logic [IDX_W-1:0] w_wr_idx;

    assign w_arb_en = rst_n && (r_state == RUN) && (r_count < CNT_W'(DEPTH));

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (req_valid),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_push_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_gnt[i]) begin
                w_push_data = req_data[i];
            end
        end
    end

    assign req_ready  = w_gnt;
    assign w_push     = |w_gnt;
    assign w_head_vld = (r_count != '0);
    assign w_pop      = w_head_vld && out_ready;

`ifdef REQQ_BYPASS_EN
    assign w_bypass  = w_push && !w_head_vld && out_ready && (r_state == RUN);
    assign out_valid = w_head_vld || w_bypass;
    assign out_data  = w_bypass ? w_push_data : r_mem[0];
`else
    assign w_bypass  = 1'b0;
    assign out_valid = w_head_vld;
    assign out_data  = r_mem[0];
`endif

    assign w_store  = w_push && !w_bypass;
    // With a same-cycle pop the tail slot moves down by one before the write.
    assign w_wr_idx = w_pop ? IDX_W'(r_count - CNT_W'(1)) : IDX_W'(r_count);

    always_comb begin
        w_state_nxt = r_state;
        w_drain_fin = 1'b0;
        case (r_state)
            RUN: begin
                if (drain) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop)) begin
                    w_state_nxt = RUN;
                    w_drain_fin = 1'b1;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_drain_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_drain_done <= w_drain_fin;
        end
    end

    // Shift register storage: head at index 0, pop shifts everything down.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            for (int j = 0; j < int'(DEPTH); j++) begin
                r_mem[j] <= '0;
            end
        end else begin
            if (w_pop) begin
                for (int j = 0; j < int'(DEPTH) - 1; j++) begin
                    r_mem[j] <= r_mem[j+1];
                end
                r_mem[DEPTH-1] <= '0;
            end
            if (w_store) begin
                r_mem[w_wr_idx] <= w_push_data;
            end
            r_count <= r_count + CNT_W'(w_store) - CNT_W'(w_pop);
        end
    end

    assign count      = r_count;
    assign full       = (r_count == CNT_W'(DEPTH));
    assign drain_done = r_drain_done;

endmodule

// File: tb/tb_req_queue_ctrl.sv
// Bench for req_queue_ctrl: queue-based reference model checked every cycle plus directed literal checks.
module tb_req_queue_ctrl;

    localparam int W = 32;
    localparam int D = 8;
    localparam int N = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0][W-1:0]  req_data;
    logic [N-1:0]         req_ready;
    logic                 out_valid;
    logic [W-1:0]         out_data;
    logic                 out_ready;
    logic                 drain;
    logic                 drain_done;
    logic [3:0]           count;
    logic                 full;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    req_queue_ctrl #(.WIDTH(W), .DEPTH(D), .NREQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .drain      (drain),
        .drain_done (drain_done),
        .count      (count),
        .full       (full)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an unbounded queue capped at D, a drain flag and a rotating priority index.
    logic [W-1:0] mq[$];
    bit           m_drain = 1'b0;
    int           m_prio  = 0;
    bit           m_dd    = 1'b0;
    bit           m_live  = 1'b0;

    always @(negedge clk) begin
        int           g;
        int           c;
        bit           pop;
        bit           byp;
        bit           fin;
        logic [N-1:0] exp_rr;
        logic         exp_ov;
        logic [W-1:0] exp_od;

        g = -1;
        if (rst_n && !m_drain && mq.size() < D) begin
            for (int k = 0; k < N; k++) begin
                c = (m_prio + k) % N;
                if (g < 0 && req_valid[c]) g = c;
            end
        end
        exp_rr = (g >= 0) ? (N'(1) << g) : '0;
        pop    = (mq.size() != 0) && out_ready;
`ifdef REQQ_BYPASS_EN
        byp = (g >= 0) && (mq.size() == 0) && out_ready;
`else
        byp = 1'b0;
`endif
        exp_ov = (mq.size() != 0) || byp;
        exp_od = byp ? req_data[g] : ((mq.size() != 0) ? mq[0] : '0);

        if (m_live && rst_n) begin
            chk("m_req_ready", W'(req_ready), W'(exp_rr));
            chk("m_out_valid", W'(out_valid), W'(exp_ov));
            if (exp_ov) chk("m_out_data", out_data, exp_od);
            chk("m_count", W'(count), W'(mq.size()));
            chk("m_full", W'(full), W'(mq.size() == D));
            chk("m_drain_done", W'(drain_done), W'(m_dd));
        end

        if (!rst_n) begin
            mq.delete();
            m_drain = 1'b0;
            m_prio  = 0;
            m_dd    = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            fin = m_drain && ((mq.size() == 0) || (mq.size() == 1 && pop));
            if (pop) mq.delete(0);
            if (g >= 0 && !byp) mq.push_back(req_data[g]);
            if (g >= 0) m_prio = (g + 1) % N;
            if (!m_drain && drain) m_drain = 1'b1;
            else if (fin)          m_drain = 1'b0;
            m_dd = fin;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [N-1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic ordy, input logic dr);
        req_valid   = v;
        req_data[0] = d0;
        req_data[1] = d1;
        out_ready   = ordy;
        drain       = dr;
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(2'b00, 0, 0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Reset state
        drv(2'b00, 0, 0, 1'b0, 1'b0);
        chk("rst_req_ready", W'(req_ready), 0);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_drain_done", W'(drain_done), 0);
        chk("rst_full", W'(full), 0);
        chk("rst_count", W'(count), 0);
        cyc();

        // Two requesters held: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) begin
            drv(2'b11, 32'hA0, 32'hB1, 1'b0, 1'b0);
            chk("rr_grant", W'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            cyc();
        end
        drv(2'b00, 0, 0, 1'b0, 1'b0);
        chk("rr_count4", W'(count), 4);
        chk("rr_head", out_data, 32'hA0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            drv(2'b00, 0, 0, 1'b1, 1'b0);
            chk("rr_pop_order", out_data, (i % 2 == 0) ? 32'hA0 : 32'hB1);
            cyc();
        end

        // Fill to full, then a pop alone does not admit a push
        for (int i = 0; i < D; i++) begin
            drv(2'b01, 32'h10 + i, 0, 1'b0, 1'b0);
            chk("fill_grant", W'(req_ready), 1);
            cyc();
        end
        drv(2'b01, 32'h77, 0, 1'b0, 1'b0);
        chk("full_flag", W'(full), 1);
        chk("full_count", W'(count), 8);
        chk("full_no_ready", W'(req_ready), 0);
        cyc();
        drv(2'b01, 32'h77, 0, 1'b1, 1'b0);
        chk("full_pop_no_ready", W'(req_ready), 0);
        cyc();
        drv(2'b01, 32'h78, 0, 1'b1, 1'b0);
        chk("count7", W'(count), 7);
        chk("count7_ready", W'(req_ready), 1);
        cyc();
        drv(2'b00, 0, 0, 1'b0, 1'b0);
        chk("count7_hold", W'(count), 7);
        chk("count7_head", out_data, 32'h12);
        cyc();
        for (int i = 0; i < 7; i++) begin
            drv(2'b00, 0, 0, 1'b1, 1'b0);
            cyc();
        end

        // count=3, simultaneous push of 0xA5 and pop
        for (int i = 0; i < 3; i++) begin
            drv(2'b01, 32'h31 + i, 0, 1'b0, 1'b0);
            cyc();
        end
        drv(2'b01, 32'hA5, 0, 1'b1, 1'b0);
        chk("pp_ready", W'(req_ready), 1);
        chk("pp_count_before", W'(count), 3);
        cyc();
        drv(2'b00, 0, 0, 1'b0, 1'b0);
        chk("pp_count_after", W'(count), 3);
        chk("pp_head", out_data, 32'h32);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drv(2'b00, 0, 0, 1'b1, 1'b0);
            chk("pp_order", out_data, (i == 0) ? 32'h32 : ((i == 1) ? 32'h33 : 32'hA5));
            cyc();
        end

        // Drain with five entries; a second drain inside DRAIN is ignored
        for (int i = 0; i < 5; i++) begin
            drv(2'b01, 32'h51 + i, 0, 1'b0, 1'b0);
            cyc();
        end
        drv(2'b00, 0, 0, 1'b0, 1'b1);
        chk("dr_count5", W'(count), 5);
        cyc();
        for (int i = 0; i < 5; i++) begin
            drv(2'b01, 32'hEE, 0, 1'b1, (i == 1));
            chk("dr_no_ready", W'(req_ready), 0);
            chk("dr_pop_data", out_data, 32'h51 + i);
            chk("dr_done_early", W'(drain_done), 0);
            cyc();
        end
        drv(2'b00, 0, 0, 1'b0, 1'b0);
        chk("dr_done", W'(drain_done), 1);
        chk("dr_empty", W'(count), 0);
        cyc();
        drv(2'b01, 32'h66, 0, 1'b0, 1'b0);
        chk("dr_done_one_cycle", W'(drain_done), 0);
        chk("dr_back_run", W'(req_ready), 1);
        cyc();
        drv(2'b00, 0, 0, 1'b1, 1'b0);
        cyc();

        // Drain on an empty queue: one DRAIN cycle, then the pulse
        drv(2'b00, 0, 0, 1'b0, 1'b1);
        cyc();
        drv(2'b01, 32'h99, 0, 1'b0, 1'b0);
        chk("edr_no_ready", W'(req_ready), 0);
        chk("edr_not_yet", W'(drain_done), 0);
        cyc();
        drv(2'b00, 0, 0, 1'b0, 1'b0);
        chk("edr_done", W'(drain_done), 1);
        cyc();
        drv(2'b00, 0, 0, 1'b0, 1'b0);
        chk("edr_done_clear", W'(drain_done), 0);
        cyc();

        // Reset mid-DRAIN with four entries
        for (int i = 0; i < 4; i++) begin
            drv(2'b01, 32'h71 + i, 0, 1'b0, 1'b0);
            cyc();
        end
        drv(2'b00, 0, 0, 1'b0, 1'b1);
        cyc();
        drv(2'b01, 32'hEE, 0, 1'b0, 1'b0);
        chk("mr_count4", W'(count), 4);
        chk("mr_in_drain", W'(req_ready), 0);
        cyc();
        rst_n = 1'b0;
        drv(2'b01, 32'hEE, 0, 1'b1, 1'b0);
        chk("mr_ready_in_reset", W'(req_ready), 0);
        cyc();
        rst_n = 1'b1;
        drv(2'b00, 0, 0, 1'b0, 1'b0);
        chk("mr_count0", W'(count), 0);
        chk("mr_out_valid", W'(out_valid), 0);
        chk("mr_no_done", W'(drain_done), 0);
        cyc();
        drv(2'b11, 32'hC0, 32'hC1, 1'b0, 1'b0);
        chk("mr_no_done_later", W'(drain_done), 0);
        chk("mr_prio_reset", W'(req_ready), 1);
        cyc();
        drv(2'b00, 0, 0, 1'b1, 1'b0);
        cyc();

        // Empty queue, out_ready=1, requester 1 offers 0x1234
        drv(2'b10, 0, 32'h1234, 1'b1, 1'b0);
        chk("bp_grant", W'(req_ready), 2);
`ifdef REQQ_BYPASS_EN
        chk("bp_out_valid", W'(out_valid), 1);
        chk("bp_out_data", out_data, 32'h1234);
        cyc();
        drv(2'b00, 0, 0, 1'b0, 1'b0);
        chk("bp_count0", W'(count), 0);
        cyc();
`else
        chk("nbp_out_valid", W'(out_valid), 0);
        cyc();
        drv(2'b00, 0, 0, 1'b1, 1'b0);
        chk("nbp_head_valid", W'(out_valid), 1);
        chk("nbp_head_data", out_data, 32'h1234);
        cyc();
`endif
        drv(2'b00, 0, 0, 1'b0, 1'b0);
        chk("end_count", W'(count), 0);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/req_queue_ctrl.md
REQ_QUEUE_CTRL -- requirements
Module: req_queue_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, queue entries (power of two, >=2).
REQ-003 SHALL have parameter NREQ, default 2, number of requesters (>=2).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester request.
REQ-007 SHALL have port req_data  input  NREQ x WIDTH  per-requester payload.
REQ-008 SHALL have port req_ready  output  NREQ  one-hot grant; at most one bit set.
REQ-009 SHALL have port out_valid  output  1  queue head valid.
REQ-010 SHALL have port out_data  output  WIDTH  queue head payload.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head.
REQ-012 SHALL have port drain  input  1  drain request pulse.
REQ-013 SHALL have port drain_done  output  1  one-cycle pulse when drain completes.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.
REQ-015 SHALL have port full  output  1  count==DEPTH.

Function
REQ-016 SHALL be a push handshake: req_valid[i]&&req_ready[i]; pop handshake: out_valid&&out_ready.
REQ-017 SHALL assert req_ready combinationally only in RUN state with count<DEPTH, for exactly one valid requester chosen round-robin; no push when full, even with a same-cycle pop.
REQ-018 SHALL give requester 0 highest priority after reset; after a grant to i, the next priority goes to (i+1) mod NREQ; the pointer holds when no grant.
REQ-019 SHALL store entries in order, head at index 0; a pop shifts all entries down by one.
REQ-020 SHALL drive out_valid = (count!=0) and out_data = entry 0, both registered state.
REQ-021 SHALL make a push into an empty queue visible at the head on the next cycle (1-cycle latency).
REQ-022 SHALL handle simultaneous push and pop: count unchanged, new entry written at index count-1 after the shift, order preserved.
REQ-023 SHALL leave count in 0..DEPTH; underflow and overflow are impossible by construction.
REQ-024 SHALL implement FSM states RUN and DRAIN; RUN->DRAIN on drain=1; DRAIN->RUN when count==0, or immediately when count==1 and a pop occurs that cycle.
REQ-025 SHALL in DRAIN hold req_ready at 0 while pops continue normally.
REQ-026 SHALL pulse drain_done for exactly one cycle on the DRAIN->RUN transition; drain asserted with an empty queue gives one DRAIN cycle, then the pulse.
REQ-027 SHALL ignore drain while already in DRAIN.

Reset
REQ-028 SHALL on rst_n=0 at posedge set count=0, state=RUN, priority pointer=0, all valid bits 0, and data entries 0.
REQ-029 SHALL during and immediately after reset drive out_valid=0, req_ready=0, drain_done=0, full=0, and out_data=0.
REQ-030 SHALL discard all entries and any drain in progress on reset mid-operation, without a drain_done pulse.

Configuration
REQ-031 SHALL with REQQ_BYPASS_EN defined, when count==0, state RUN, and out_ready=1, drive the granted payload combinationally to out_data with out_valid=1; the payload is not stored and count stays 0.
REQ-032 SHALL without REQQ_BYPASS_EN never present a payload on out_data in its push cycle (REQ-021 latency only).

Structure
REQ-033 SHALL place the FSM state enum (RUN, DRAIN) and default parameter constants in package req_queue_pkg.
REQ-034 SHALL implement round-robin selection in sub-module rr_arbiter (inputs request vector, enable; output one-hot grant; internal pointer).

Verification
REQ-035 SHALL cover: req_valid=2'b11 held 4 cycles, out_ready=0 -> grants 0,1,0,1; count=4; head=data of requester 0.
REQ-036 SHALL cover: fill to DEPTH=8 with out_ready=0 -> full=1, req_ready=0; then out_ready=1 with req_valid=1 -> no push until count=7.
REQ-037 SHALL cover: count=3 with simultaneous push of 0xA5 and pop -> count stays 3; 0xA5 pops after the two older entries.
REQ-038 SHALL cover: count=5, drain pulse, out_ready=1 -> req_ready=0 for 5 cycles, drain_done on the 5th pop, then RUN.
REQ-039 SHALL cover: rst_n=0 for one cycle mid-DRAIN with count=4 -> next cycle count=0, out_valid=0, no drain_done.
REQ-040 SHALL cover with REQQ_BYPASS_EN: empty, out_ready=1, req_valid[1]=1 with data 0x1234 -> out_valid=1, out_data=0x1234 same cycle, count stays 0.
